// File: rtl/tang_keyed_tx.sv
// Keyed carrier transmitter: synchronised and debounced push button gates a
// square-wave carrier, with optional hang time after release and a heartbeat LED.
module tang_keyed_tx #(
    parameter int TX_DIV     = 4,
    parameter int DEBOUNCE   = 270000,
    parameter int HANG       = 0,
    parameter int BLINK_HALF = 8388608,
    parameter int CNT_W      = 25
) (
    input  logic clk_27MHz,
    input  logic rst,
    input  logic key,
    output logic status_led,
    output logic key_led,
    output logic keyed,
    output logic tx_out
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_KEYED = 2'd1,
        ST_HANG  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] TX_LAST    = CNT_W'(TX_DIV - 1);
    localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_HALF - 1);
    localparam logic [CNT_W-1:0] HANG_LAST  = CNT_W'((HANG > 0) ? (HANG - 1) : 0);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic             sync1_q, sync2_q;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] dcnt_q, dcnt_d;
    logic [CNT_W-1:0] bcnt_q, bcnt_d;
    logic             blink_q, blink_d;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] ccnt_q, ccnt_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic             tx_q, tx_d;
    logic             keyed_q, keyed_d;
    logic             run_carrier;

    // A press is only accepted once the synchronised key has differed from
    // the accepted level for DEBOUNCE consecutive cycles.
    always_comb begin
        stable_d = stable_q;
        dcnt_d   = dcnt_q;
        if (sync2_q == stable_q) begin
            dcnt_d = '0;
        end else if (dcnt_q == DEB_LAST) begin
            stable_d = sync2_q;
            dcnt_d   = '0;
        end else begin
            dcnt_d = dcnt_q + CNT_ONE;
        end
    end

    always_comb begin
        blink_d = blink_q;
        if (bcnt_q == BLINK_LAST) begin
            bcnt_d  = '0;
            blink_d = ~blink_q;
        end else begin
            bcnt_d = bcnt_q + CNT_ONE;
        end
    end

    always_comb begin
        state_d     = state_q;
        ccnt_d      = ccnt_q;
        hcnt_d      = hcnt_q;
        tx_d        = tx_q;
        run_carrier = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!stable_q) state_d = ST_KEYED;
            end
            ST_KEYED: begin
                run_carrier = 1'b1;
                if (stable_q) begin
                    if (HANG > 0) begin
                        state_d = ST_HANG;
                        hcnt_d  = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_HANG: begin
                // A re-press outranks hang expiry so the carrier never drops.
                run_carrier = 1'b1;
                if (!stable_q) begin
                    state_d = ST_KEYED;
                end else if (hcnt_q == HANG_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    hcnt_d = hcnt_q + CNT_ONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (run_carrier) begin
            if (ccnt_q == TX_LAST) begin
                ccnt_d = '0;
                tx_d   = ~tx_q;
            end else begin
                ccnt_d = ccnt_q + CNT_ONE;
            end
        end

        // Leaving for IDLE silences the carrier on the same edge.
        if (state_d == ST_IDLE) begin
            ccnt_d = '0;
            tx_d   = 1'b0;
        end
        keyed_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_27MHz or posedge rst) begin
        if (rst) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            stable_q <= 1'b1;
            dcnt_q   <= '0;
            bcnt_q   <= '0;
            blink_q  <= 1'b0;
            state_q  <= ST_IDLE;
            ccnt_q   <= '0;
            hcnt_q   <= '0;
            tx_q     <= 1'b0;
            keyed_q  <= 1'b0;
        end else begin
            sync1_q  <= key;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            dcnt_q   <= dcnt_d;
            bcnt_q   <= bcnt_d;
            blink_q  <= blink_d;
            state_q  <= state_d;
            ccnt_q   <= ccnt_d;
            hcnt_q   <= hcnt_d;
            tx_q     <= tx_d;
            keyed_q  <= keyed_d;
        end
    end

    assign status_led = blink_q;
    assign key_led    = stable_q;
    assign keyed      = keyed_q;
    assign tx_out     = tx_q;

endmodule
